// File: rtl/rgb_pwm_fader.sv
// Three-channel active-low PWM LED driver with a load handshake that either
// jumps to or linearly ramps toward a new duty triple at PWM period boundaries.
module rgb_pwm_fader #(
    parameter int unsigned PWM_BITS          = 8,
    parameter int unsigned PRESCALE          = 16,
    parameter int unsigned FADE_STEP_PERIODS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    input  logic                fade_en,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                period_start,
    output logic                fading
);

    typedef enum logic [1:0] {IDLE, PENDING, FADING} state_t;

    localparam logic [15:0]         PRE_MAX  = 16'(PRESCALE - 1);
    localparam logic [7:0]          STEP_MAX = 8'(FADE_STEP_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    state_t              state_q, state_nxt;
    logic [15:0]         pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                handshake;
    logic [7:0]          step_q, step_nxt;
    logic                fade_q;
    logic                all_eq;
    logic [PWM_BITS-1:0] duty_q   [3];
    logic [PWM_BITS-1:0] tgt_q    [3];
    logic [PWM_BITS-1:0] duty_nxt [3];

    assign tick      = (pre_cnt == PRE_MAX);
    assign handshake = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + PWM_ONE;
            period_start <= tick && (pwm_cnt == '1);
        end
    end

    always_comb begin
        state_nxt = state_q;
        step_nxt  = step_q;
        all_eq    = 1'b1;
        for (int unsigned i = 0; i < 3; i++) duty_nxt[i] = duty_q[i];

        case (state_q)
            IDLE: begin
                if (handshake) state_nxt = PENDING;
            end
            PENDING: begin
                if (period_start) begin
                    if (fade_q) begin
                        state_nxt = FADING;
                        step_nxt  = '0;
                    end else begin
                        for (int unsigned i = 0; i < 3; i++) duty_nxt[i] = tgt_q[i];
                        state_nxt = IDLE;
                    end
                end
            end
            FADING: begin
                if (period_start) begin
                    if (step_q == STEP_MAX) begin
                        step_nxt = '0;
                        for (int unsigned i = 0; i < 3; i++) begin
                            if (duty_q[i] < tgt_q[i])      duty_nxt[i] = duty_q[i] + PWM_ONE;
                            else if (duty_q[i] > tgt_q[i]) duty_nxt[i] = duty_q[i] - PWM_ONE;
                            if (duty_nxt[i] != tgt_q[i]) all_eq = 1'b0;
                        end
                        if (all_eq) state_nxt = IDLE;
                    end else begin
                        step_nxt = step_q + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // LEDs compare against the duty being written this edge, so the first
    // counter value of a new period already uses the new duty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            fade_q     <= 1'b0;
            load_ready <= 1'b1;
            fading     <= 1'b0;
            led_r      <= 1'b1;
            led_g      <= 1'b1;
            led_b      <= 1'b1;
            for (int unsigned i = 0; i < 3; i++) begin
                duty_q[i] <= '0;
                tgt_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_nxt;
            step_q     <= step_nxt;
            load_ready <= (state_nxt == IDLE);
            fading     <= (state_nxt == FADING);
            led_r      <= (pwm_cnt >= duty_nxt[0]);
            led_g      <= (pwm_cnt >= duty_nxt[1]);
            led_b      <= (pwm_cnt >= duty_nxt[2]);
            for (int unsigned i = 0; i < 3; i++) duty_q[i] <= duty_nxt[i];
            if (handshake) begin
                tgt_q[0] <= duty_r;
                tgt_q[1] <= duty_g;
                tgt_q[2] <= duty_b;
                fade_q   <= fade_en;
            end
        end
    end

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, giving the duty and PWM counter width.
REQ-002 SHALL have parameter PRESCALE, default 16, giving clk cycles per PWM tick (legal range 1..65535).
REQ-003 SHALL have parameter FADE_STEP_PERIODS, default 4, giving PWM periods per fade step (legal range 1..255).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 SHALL have port load_valid, input, 1 bit, new duty triple offered.
REQ-007 SHALL have port load_ready, output, 1 bit, block accepts a duty triple.
REQ-008 SHALL have ports duty_r, duty_g and duty_b, input, PWM_BITS each, target duty per channel.
REQ-009 SHALL have port fade_en, input, 1 bit, 1 = ramp to the target, 0 = jump to the target.
REQ-010 SHALL have ports led_r, led_g and led_b, output, 1 bit each, active-low LED drive (0 = lit).
REQ-011 SHALL have port period_start, output, 1 bit, one-cycle pulse at each PWM period boundary.
REQ-012 SHALL have port fading, output, 1 bit, high while a ramp is in progress.

Function
REQ-013 SHALL count the prescaler 0..PRESCALE-1 and assert the internal tick on the cycle where the count equals PRESCALE-1, then wrap to 0.
REQ-014 SHALL increment the PWM counter on each tick and wrap it from 2^PWM_BITS-1 to 0.
REQ-015 SHALL pulse period_start for exactly one clk on the cycle in which the PWM counter wraps to 0.
REQ-016 SHALL light a channel (registered; 1-clk latency from counter update) while PWM counter < that channel's current duty.
- Duty 0 = never lit.
- Duty 2^PWM_BITS-1 = lit (2^PWM_BITS-1)/2^PWM_BITS of the period.
REQ-017 SHALL implement states IDLE, PENDING and FADING.
- load_ready = 1 only in IDLE; it is a registered output.
REQ-018 SHALL complete a handshake on a clk edge with load_valid=1 and load_ready=1.
- On that edge: latch duty_r/g/b into target registers, sample fade_en, and go IDLE->PENDING.
REQ-019 SHALL ignore load_valid while load_ready=0, leaving targets unchanged.
REQ-020 SHALL leave PENDING only on a period_start that occurs strictly after the handshake cycle.
- A handshake coinciding with period_start waits for the following boundary.
REQ-021 SHALL, at that boundary with sampled fade_en=0, copy targets to current duties and return to IDLE.
REQ-022 SHALL, at that boundary with sampled fade_en=1, enter FADING and assert fading.
REQ-023 SHALL, in FADING, step every channel whose current duty differs from its target by 1 toward the target.
- A step occurs every FADE_STEP_PERIODS period boundaries, counted from FADING entry.
- Duties never overshoot and never wrap.
REQ-024 SHALL return FADING->IDLE and deassert fading on the step that makes all three current duties equal their targets.
- If the targets already equal the current duties at entry, exit at the first step boundary.
REQ-025 SHALL change current duties only at period boundaries, so no PWM period is truncated or glitched.

Reset
REQ-026 SHALL, while rst=0, immediately (no clock edge needed) force the following, abandoning any PENDING or FADING operation:
- Prescaler, PWM counter, fade step counter, current duties and targets = 0.
- State = IDLE.
- led_r/g/b = 1, period_start = 0, fading = 0, load_ready = 1.
REQ-027 SHALL begin counting on the first rising clk edge after rst returns to 1.

Verification
REQ-028 Bench SHALL cover each scenario below; all use PWM_BITS=8, PRESCALE=1 (period 256 clk) and FADE_STEP_PERIODS=1.
- Reset: hold rst=0 for 5 clk -> led_r/g/b=1, load_ready=1, period_start=0, fading=0 throughout.
- Jump load: load r=64, g=0, b=255 with fade_en=0 -> from the next period boundary, each 256-clk period shows led_r=0 for 64 clk, led_g=1 for all 256, led_b=0 for 255; load_ready=1 the cycle after apply.
- Fade: from 0, load r=3, g=0, b=0 with fade_en=1 -> r lit 1, 2, 3 clk on successive periods; fading high for 3 periods, then 0; load_ready then 1.
- Busy reject: assert load_valid with r=200 during FADING -> load_ready=0, no latch; the ramp still ends at the original target.
- Boundary coincidence: handshake on the same cycle as period_start -> new duty visible only after the next period_start, 256 clk later.
- Mid-fade reset: drop rst between clock edges during FADING -> all outputs reach reset values before the next clk edge; after release, IDLE with duty 0.
